systolic_pe_v2: RTL and testbench

SYSTOLIC_PE_V2 -- requirements
Module: systolic_pe_v2

---
 rtl/systolic_pe_v2.sv | 112 +++++++++++
 tb/tb_systolic_pe_v2.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_pe_v2.sv
`default_nettype none
// ============================================================================
// Module : systolic_pe_v2
// Weight-stationary MAC PE: double-buffered weight, 2-stage psum, saturation.
// Rev    : 1.0
// ============================================================================
module systolic_pe_v2 #(
  parameter int DW     = 16,
  parameter int AW     = 40,
  parameter bit SIGNED = 1'b1,
  parameter bit SAT    = 1'b1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          EN,
  input  logic [DW-1:0] a_in,
  input  logic          a_vld_in,
  output logic [DW-1:0] a_out,
  output logic          a_vld_out,
  input  logic [AW-1:0] psum_in,
  output logic [AW-1:0] psum_out,
  output logic          psum_vld_out,
  input  logic [DW-1:0] w_in,
  input  logic          w_load,
  output logic [DW-1:0] w_out,
  input  logic          w_swap,
  output logic          ovf,
  input  logic          ovf_clr
);

  logic [DW-1:0]   w_shadow;
  logic [DW-1:0]   w_act;
  logic [2*DW-1:0] prod;
  logic [AW-1:0]   psum_d;
  logic            v1;

  logic [2*DW-1:0] a_ext;
  logic [2*DW-1:0] w_ext;
  logic [2*DW-1:0] prod_nxt;
  logic [AW:0]     sum;
  logic            out_of_range;
  logic            sum_neg;
  logic [AW-1:0]   sat_hi;
  logic [AW-1:0]   sat_lo;
  logic [AW-1:0]   result;

  // Low 2*DW bits of the extended-operand product equal the true signed/unsigned product.
  assign a_ext    = {{DW{SIGNED & a_in[DW-1]}}, a_in};
  assign w_ext    = {{DW{SIGNED & w_act[DW-1]}}, w_act};
  assign prod_nxt = a_ext * w_ext;

  assign sum = {SIGNED & psum_d[AW-1], psum_d}
             + {{(AW+1-2*DW){SIGNED & prod[2*DW-1]}}, prod};

  always_comb begin
    out_of_range = 1'b0;
    sum_neg      = 1'b0;
    sat_hi       = '1;
    sat_lo       = '0;
    if (SIGNED) begin
      out_of_range = sum[AW] ^ sum[AW-1];
      sum_neg      = sum[AW];
      sat_hi       = {1'b0, {(AW-1){1'b1}}};
      sat_lo       = {1'b1, {(AW-1){1'b0}}};
    end else begin
      out_of_range = sum[AW];
    end
    result = sum[AW-1:0];
    if (SAT && out_of_range) begin
      result = sum_neg ? sat_lo : sat_hi;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      a_out        <= '0;
      a_vld_out    <= 1'b0;
      prod         <= '0;
      psum_d       <= '0;
      v1           <= 1'b0;
      psum_out     <= '0;
      psum_vld_out <= 1'b0;
      w_shadow     <= '0;
      w_act        <= '0;
    end else if (EN) begin
      a_out        <= a_in;
      a_vld_out    <= a_vld_in;
      // Swap reads the pre-edge shadow, so a same-cycle load does not leak through.
      if (w_load) w_shadow <= w_in;
      if (w_swap) w_act    <= w_shadow;
      prod         <= prod_nxt;
      psum_d       <= psum_in;
      v1           <= a_vld_in;
      psum_vld_out <= v1;
      if (v1) psum_out <= result;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ovf <= 1'b0;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end else if (EN && v1 && out_of_range) begin
      ovf <= 1'b1;
    end
  end

  assign w_out = w_shadow;

endmodule
`default_nettype wire

// File: tb/tb_systolic_pe_v2.sv
`default_nettype none
// ============================================================================
// Module : tb_systolic_pe_v2
// Directed scoreboard bench: signed SAT / signed wrap / unsigned DW=8 PEs.
// Rev    : 1.0
// ============================================================================
module tb_systolic_pe_v2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        EN = 1'b0;
  logic        ovf_clr = 1'b0;

  logic [15:0] a_in = '0;
  logic [15:0] w_in = '0;
  logic        a_vld_in = 1'b0;
  logic        w_load = 1'b0;
  logic        w_swap = 1'b0;
  logic [39:0] psum_in = '0;

  logic [15:0] a_out0, a_out1, w_out0, w_out1;
  logic        avo0, avo1, pv0, pv1, ovf0, ovf1;
  logic [39:0] po0, po1;

  logic [7:0]  u_a = '0;
  logic [7:0]  u_w = '0;
  logic        u_vld = 1'b0;
  logic        u_load = 1'b0;
  logic        u_swap = 1'b0;
  logic [15:0] u_psum = '0;
  logic [7:0]  u_aout, u_wout;
  logic        u_avo, u_pv, u_ovf;
  logic [15:0] u_po;

  int total = 0;
  int bad = 0;
  int en_cnt = 0;

  typedef struct { logic [39:0] s; logic [39:0] w; bit ov; int due; } e0_t;
  typedef struct { logic [15:0] s; bit ov; int due; } e2_t;
  e0_t q0[$];
  e2_t q2[$];

  logic [15:0] m_wsh0, m_wact0, exp_a;
  logic [7:0]  m_wsh2, m_wact2;
  logic        exp_av, exp_vld, exp_ovf, exp_vld2, exp_ovf2;
  logic [39:0] exp_p0, exp_p1;
  logic [15:0] exp_p2;

  systolic_pe_v2 #(.DW(16), .AW(40), .SIGNED(1'b1), .SAT(1'b1)) dut_sat (
    .CLK(CLK), .RESET(RESET), .EN(EN),
    .a_in(a_in), .a_vld_in(a_vld_in), .a_out(a_out0), .a_vld_out(avo0),
    .psum_in(psum_in), .psum_out(po0), .psum_vld_out(pv0),
    .w_in(w_in), .w_load(w_load), .w_out(w_out0), .w_swap(w_swap),
    .ovf(ovf0), .ovf_clr(ovf_clr)
  );

  systolic_pe_v2 #(.DW(16), .AW(40), .SIGNED(1'b1), .SAT(1'b0)) dut_wrap (
    .CLK(CLK), .RESET(RESET), .EN(EN),
    .a_in(a_in), .a_vld_in(a_vld_in), .a_out(a_out1), .a_vld_out(avo1),
    .psum_in(psum_in), .psum_out(po1), .psum_vld_out(pv1),
    .w_in(w_in), .w_load(w_load), .w_out(w_out1), .w_swap(w_swap),
    .ovf(ovf1), .ovf_clr(ovf_clr)
  );

  systolic_pe_v2 #(.DW(8), .AW(16), .SIGNED(1'b0), .SAT(1'b1)) dut_uns (
    .CLK(CLK), .RESET(RESET), .EN(EN),
    .a_in(u_a), .a_vld_in(u_vld), .a_out(u_aout), .a_vld_out(u_avo),
    .psum_in(u_psum), .psum_out(u_po), .psum_vld_out(u_pv),
    .w_in(u_w), .w_load(u_load), .w_out(u_wout), .w_swap(u_swap),
    .ovf(u_ovf), .ovf_clr(ovf_clr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void mac40(input logic [39:0] p, input logic [15:0] a, input logic [15:0] w,
                                output logic [39:0] rs, output logic [39:0] rw, output bit ov);
    longint s, mx, mn;
    s  = longint'($signed(p)) + longint'($signed(a)) * longint'($signed(w));
    mx = (longint'(1) <<< 39) - 1;
    mn = -(longint'(1) <<< 39);
    ov = (s > mx) || (s < mn);
    if (s > mx)      rs = mx[39:0];
    else if (s < mn) rs = mn[39:0];
    else             rs = s[39:0];
    rw = s[39:0];
  endfunction

  function automatic void macu16(input logic [15:0] p, input logic [7:0] a, input logic [7:0] w,
                                 output logic [15:0] rs, output bit ov);
    longint s;
    s  = longint'(p) + longint'(a) * longint'(w);
    ov = (s > 65535);
    rs = ov ? 16'hFFFF : s[15:0];
  endfunction

  task automatic check_all();
    chk("a_out_sat",   64'(a_out0), 64'(exp_a));
    chk("a_out_wrap",  64'(a_out1), 64'(exp_a));
    chk("a_vld_out",   64'(avo0),   64'(exp_av));
    chk("psum_vld",    64'(pv0),    64'(exp_vld));
    chk("psum_vld_w",  64'(pv1),    64'(exp_vld));
    chk("psum_sat",    64'(po0),    64'(exp_p0));
    chk("psum_wrap",   64'(po1),    64'(exp_p1));
    chk("w_out",       64'(w_out0), 64'(m_wsh0));
    chk("ovf_sat",     64'(ovf0),   64'(exp_ovf));
    chk("ovf_wrap",    64'(ovf1),   64'(exp_ovf));
    chk("u_psum_vld",  64'(u_pv),   64'(exp_vld2));
    chk("u_psum",      64'(u_po),   64'(exp_p2));
    chk("u_w_out",     64'(u_wout), 64'(m_wsh2));
    chk("u_ovf",       64'(u_ovf),  64'(exp_ovf2));
  endtask

  // Updates the reference model with the values present before the edge, then checks after it.
  task automatic tick();
    e0_t e;
    e2_t f;
    logic [39:0] rs, rw;
    logic [15:0] us;
    bit ov;
    if (!RESET) begin
      q0.delete(); q2.delete();
      m_wsh0 = '0; m_wact0 = '0; m_wsh2 = '0; m_wact2 = '0;
      exp_a = '0; exp_av = 1'b0; exp_vld = 1'b0; exp_vld2 = 1'b0;
      exp_p0 = '0; exp_p1 = '0; exp_p2 = '0; exp_ovf = 1'b0; exp_ovf2 = 1'b0;
    end else begin
      if (EN) begin
        en_cnt++;
        exp_vld = 1'b0;
        if (q0.size() > 0 && q0[0].due == en_cnt) begin
          e = q0.pop_front();
          exp_vld = 1'b1; exp_p0 = e.s; exp_p1 = e.w;
          if (e.ov) exp_ovf = 1'b1;
        end
        exp_vld2 = 1'b0;
        if (q2.size() > 0 && q2[0].due == en_cnt) begin
          f = q2.pop_front();
          exp_vld2 = 1'b1; exp_p2 = f.s;
          if (f.ov) exp_ovf2 = 1'b1;
        end
        exp_a = a_in; exp_av = a_vld_in;
        if (a_vld_in) begin
          mac40(psum_in, a_in, m_wact0, rs, rw, ov);
          e.s = rs; e.w = rw; e.ov = ov; e.due = en_cnt + 1;
          q0.push_back(e);
        end
        if (u_vld) begin
          macu16(u_psum, u_a, m_wact2, us, ov);
          f.s = us; f.ov = ov; f.due = en_cnt + 1;
          q2.push_back(f);
        end
        if (w_swap) m_wact0 = m_wsh0;
        if (w_load) m_wsh0 = w_in;
        if (u_swap) m_wact2 = m_wsh2;
        if (u_load) m_wsh2 = u_w;
      end
      if (ovf_clr) begin exp_ovf = 1'b0; exp_ovf2 = 1'b0; end
    end
    @(posedge CLK);
    #1;
    check_all();
  endtask

  initial begin
    EN = 1'b1;
    RESET = 1'b0;
    tick(); tick();
    RESET = 1'b1;

    // basic MAC: weight 3, a=-5, psum 100; unsigned PE 255*255
    w_in = 16'd3; w_load = 1'b1; u_w = 8'd255; u_load = 1'b1; tick();
    w_load = 1'b0; u_load = 1'b0; w_swap = 1'b1; u_swap = 1'b1; tick();
    w_swap = 1'b0; u_swap = 1'b0;
    a_in = -16'sd5; a_vld_in = 1'b1; psum_in = 40'd100;
    u_a = 8'd255; u_vld = 1'b1; u_psum = 16'd0; tick();
    chk("mac_a_out", 64'(a_out0), 64'(16'hFFFB));
    a_vld_in = 1'b0; u_vld = 1'b0; tick();
    chk("mac_85", 64'(po0), 64'd85);
    chk("uns_65025", 64'(u_po), 64'd65025);
    tick();

    // simultaneous load and swap
    w_in = 16'd7; w_load = 1'b1; tick();
    w_in = 16'd9; w_swap = 1'b1; tick();
    w_load = 1'b0; w_swap = 1'b0;
    chk("ldswap_w_out", 64'(w_out0), 64'd9);
    a_in = 16'd2; a_vld_in = 1'b1; psum_in = 40'd0; tick();
    a_vld_in = 1'b0; tick();
    chk("ldswap_14", 64'(po0), 64'd14);

    // back-to-back valid burst, mixed signs
    for (int i = 0; i < 4; i++) begin
      a_in = 16'(i * 3 - 4); a_vld_in = 1'b1; psum_in = 40'(i * 1000 - 1500);
      u_a = 8'(i * 50 + 3); u_vld = 1'b1; u_psum = 16'(i * 100);
      tick();
    end
    a_vld_in = 1'b0; u_vld = 1'b0; tick(); tick();

    // positive saturation / wrap, unsigned saturation
    w_in = 16'd4; w_load = 1'b1; tick();
    w_load = 1'b0; w_swap = 1'b1; tick();
    w_swap = 1'b0;
    a_in = 16'd4; a_vld_in = 1'b1; psum_in = (40'd1 << 39) - 40'd10;
    u_a = 8'd255; u_vld = 1'b1; u_psum = 16'd1000; tick();
    a_vld_in = 1'b0; u_vld = 1'b0; tick();
    chk("sat_max", 64'(po0), 64'(40'h7F_FFFF_FFFF));
    chk("wrap_val", 64'(po1), 64'(40'h80_0000_0006));
    chk("sat_ovf", 64'(ovf0), 64'd1);
    chk("u_sat_max", 64'(u_po), 64'(16'hFFFF));

    // clear works while stalled
    ovf_clr = 1'b1; EN = 1'b0; tick();
    ovf_clr = 1'b0; EN = 1'b1;

    // negative saturation with clear on the same edge as the overflow
    a_in = -16'sd4; a_vld_in = 1'b1; psum_in = 40'h80_0000_0005; tick();
    a_vld_in = 1'b0; ovf_clr = 1'b1; tick();
    ovf_clr = 1'b0;
    chk("sat_min", 64'(po0), 64'(40'h80_0000_0000));

    // lands exactly on the max: no overflow
    a_in = 16'd4; a_vld_in = 1'b1; psum_in = (40'd1 << 39) - 40'd17; tick();

    // stall with a valid product in stage 1; load/swap during stall ignored
    a_in = 16'd6; a_vld_in = 1'b1; psum_in = 40'd1000; tick();
    a_vld_in = 1'b0; a_in = 16'd77; EN = 1'b0;
    w_in = 16'd99; w_load = 1'b1; w_swap = 1'b1;
    tick(); tick(); tick();
    EN = 1'b1; w_load = 1'b0; w_swap = 1'b0; tick();
    chk("stall_1024", 64'(po0), 64'd1024);
    a_in = 16'd1; a_vld_in = 1'b1; psum_in = 40'd0; tick();
    a_vld_in = 1'b0; tick();
    chk("stall_w_kept", 64'(po0), 64'd4);

    // asynchronous reset mid-pipeline
    a_in = 16'd5; a_vld_in = 1'b1; psum_in = 40'd0; u_vld = 1'b1; tick();
    a_vld_in = 1'b0; u_vld = 1'b0;
    #2 RESET = 1'b0;
    #1;
    chk("rst_psum",  64'(po0),    64'd0);
    chk("rst_pvld",  64'(pv0),    64'd0);
    chk("rst_a_out", 64'(a_out0), 64'd0);
    chk("rst_avld",  64'(avo0),   64'd0);
    chk("rst_w_out", 64'(w_out0), 64'd0);
    chk("rst_u_pvld", 64'(u_pv),  64'd0);
    tick(); tick();
    RESET = 1'b1;
    tick(); tick(); tick();
    a_in = 16'd3; a_vld_in = 1'b1; psum_in = 40'd50; tick();
    a_vld_in = 1'b0; tick();
    chk("post_rst_50", 64'(po0), 64'd50);
    tick(); tick();

    chk("sb_empty", 64'(q0.size() + q2.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
